// File: rtl/ps2_frame_receiver_if.sv
// PS/2 receiver bus: debounced line inputs plus received-byte and key-event outputs.
// The receiver takes the slave modport; the driver of the lines and the consumer take master.
interface ps2_frame_receiver_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_error;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_break;
  logic       key_valid;

  modport master (
    output ps2_clk, ps2_data,
    input  rx_byte, rx_valid, rx_error, key_code, key_extended, key_break, key_valid
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output rx_byte, rx_valid, rx_error, key_code, key_extended, key_break, key_valid
  );
endinterface

// File: rtl/ps2_frame_receiver.sv
// Deserialises 11-bit PS/2 device-to-host frames into bytes, with parity/stop/timeout checks,
// and folds E0/F0 prefixes into single key events.
module ps2_frame_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic              clk,
  input logic              rst,
  ps2_frame_receiver_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] ToLast = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic [0:0]      state;
  logic            clk_prev;
  logic [3:0]      bit_cnt;
  logic [7:0]      data_sr;
  logic            parity_bit;
  logic [CntW-1:0] to_cnt;
  logic [7:0]      rx_byte;
  logic            rx_valid;
  logic            rx_error;
  logic [7:0]      key_code;
  logic            key_extended;
  logic            key_break;
  logic            key_valid;
  logic            pend_ext;
  logic            pend_brk;

  logic fall;
  logic frame_good;

  assign fall       = clk_prev & ~bus.ps2_clk;
  // Evaluated in the stop-bit fall cycle: odd parity over data+parity, stop must be high.
  assign frame_good = (^data_sr ^ parity_bit) & bus.ps2_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      clk_prev     <= 1'b1;
      bit_cnt      <= 4'd0;
      data_sr      <= 8'h00;
      parity_bit   <= 1'b0;
      to_cnt       <= '0;
      rx_byte      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_error     <= 1'b0;
      key_code     <= 8'h00;
      key_extended <= 1'b0;
      key_break    <= 1'b0;
      key_valid    <= 1'b0;
      pend_ext     <= 1'b0;
      pend_brk     <= 1'b0;
    end else begin
      clk_prev  <= bus.ps2_clk;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
      key_valid <= 1'b0;

      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (fall && !bus.ps2_data) begin
            state   <= RECV;
            bit_cnt <= 4'd1;
          end
        end
        RECV: begin
          if (fall) begin
            to_cnt  <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt <= 4'd8) begin
              data_sr[3'(bit_cnt - 4'd1)] <= bus.ps2_data;
            end else if (bit_cnt == 4'd9) begin
              parity_bit <= bus.ps2_data;
            end else begin
              state   <= IDLE;
              bit_cnt <= 4'd0;
              if (frame_good) begin
                rx_byte  <= data_sr;
                rx_valid <= 1'b1;
              end else begin
                rx_error <= 1'b1;
              end
            end
          end else if (to_cnt == ToLast) begin
            // Stalled frame: drop partial bits and report once.
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            to_cnt   <= '0;
            rx_error <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Prefix decoder works off the registered byte stream.
      if (rx_valid) begin
        if (rx_byte == 8'hE0) begin
          pend_ext <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          pend_brk <= 1'b1;
        end else begin
          key_valid    <= 1'b1;
          key_code     <= rx_byte;
          key_extended <= pend_ext;
          key_break    <= pend_brk;
          pend_ext     <= 1'b0;
          pend_brk     <= 1'b0;
        end
      end else if (rx_error) begin
        pend_ext <= 1'b0;
        pend_brk <= 1'b0;
      end
    end
  end

  assign bus.rx_byte      = rx_byte;
  assign bus.rx_valid     = rx_valid;
  assign bus.rx_error     = rx_error;
  assign bus.key_code     = key_code;
  assign bus.key_extended = key_extended;
  assign bus.key_break    = key_break;
  assign bus.key_valid    = key_valid;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Scoreboard bench for ps2_frame_receiver: stimulus pushes expected bytes/errors/key events,
// a negedge monitor pops and compares whenever the receiver pulses an output.
module tb_ps2_frame_receiver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_frame_receiver_if bus ();

  ps2_frame_receiver #(
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] b;
  } rx_exp_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_exp_t;

  rx_exp_t  rx_q[$];
  key_exp_t key_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the head of its queue.
  always @(negedge clk) begin
    rx_exp_t  re;
    key_exp_t ke;
    if (bus.rx_valid || bus.rx_error) begin
      chk("rx_valid_error_overlap", 32'(bus.rx_valid & bus.rx_error), 32'd0);
      if (rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got valid=%b error=%b byte=%h expected no pulse",
                 bus.rx_valid, bus.rx_error, bus.rx_byte);
      end else begin
        re = rx_q.pop_front();
        chk("rx_error_flag", 32'(bus.rx_error), 32'(re.err));
        if (!re.err) chk("rx_byte", 32'(bus.rx_byte), 32'(re.b));
      end
    end
    if (bus.key_valid) begin
      if (key_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL key_unexpected: got code=%h ext=%b brk=%b expected no pulse",
                 bus.key_code, bus.key_extended, bus.key_break);
      end else begin
        ke = key_q.pop_front();
        chk("key_code", 32'(bus.key_code), 32'(ke.code));
        chk("key_extended", 32'(bus.key_extended), 32'(ke.ext));
        chk("key_break", 32'(bus.key_break), 32'(ke.brk));
      end
    end
  end

  task automatic exp_rx(input logic [7:0] b);
    rx_q.push_back('{err: 1'b0, b: b});
  endtask

  task automatic exp_err();
    rx_q.push_back('{err: 1'b1, b: 8'h00});
  endtask

  task automatic exp_key(input logic [7:0] code, input logic ext, input logic brk);
    key_q.push_back('{code: code, ext: ext, brk: brk});
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.ps2_data = b;
    repeat (5) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (10) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(stop);
    bus.ps2_data = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && (rx_q.size() != 0 || key_q.size() != 0); i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk({name, "_rx_pending"}, 32'(rx_q.size()), 32'd0);
    chk({name, "_key_pending"}, 32'(key_q.size()), 32'd0);
    rx_q.delete();
    key_q.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_rx_byte"}, 32'(bus.rx_byte), 32'd0);
    chk({name, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
    chk({name, "_rx_error"}, 32'(bus.rx_error), 32'd0);
    chk({name, "_key_code"}, 32'(bus.key_code), 32'd0);
    chk({name, "_key_ext"}, 32'(bus.key_extended), 32'd0);
    chk({name, "_key_brk"}, 32'(bus.key_break), 32'd0);
    chk({name, "_key_valid"}, 32'(bus.key_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Plain make code
    exp_rx(8'h1C); exp_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("t1", 100);
    chk("t1_key_hold", 32'(bus.key_code), 32'h1C);

    // Break of a plain key
    exp_rx(8'hF0); exp_rx(8'h1C); exp_key(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("t2", 100);

    // Extended break, then plain make
    exp_rx(8'hE0); exp_rx(8'hF0); exp_rx(8'h75); exp_key(8'h75, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    drain("t3a", 100);
    chk("t3_brk_hold", 32'(bus.key_break), 32'd1);
    exp_rx(8'h75); exp_key(8'h75, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1);
    drain("t3b", 100);

    // Parity error leaves rx_byte holding the last good byte
    exp_err();
    send_frame(8'h1C, 1'b1, 1'b1);
    drain("t4a", 100);
    chk("t4_rx_byte_hold", 32'(bus.rx_byte), 32'h75);
    exp_rx(8'h1C); exp_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("t4b", 100);

    // Timeout after start + 4 data bits
    exp_err();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    bus.ps2_data = 1'b1;
    repeat (150) @(negedge clk);
    drain("t5a", 150);
    exp_rx(8'h29); exp_key(8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1);
    drain("t5b", 100);
    chk("t5_rx_byte", 32'(bus.rx_byte), 32'h29);

    // Error drops a pending E0
    exp_rx(8'hE0); exp_err(); exp_rx(8'h1C); exp_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("t6a", 100);

    // Reset mid-prefix and mid-frame discards everything
    exp_rx(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1);
    drain("t6b", 100);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    bus.ps2_data = 1'b1;
    repeat (300) @(negedge clk);
    exp_rx(8'h1C); exp_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    drain("t6c", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
